flash_store: RTL and testbench

- Behavioural record store sitting directly downstream of the password-keeper top level.
- Consumes flash_write, add_flash and write_data_flash; returns data_flash and max_address for boot loading.
- Models a small NOR-style flash: one-cycle registered reads, multi-cycle program and erase with a busy indication, and a valid bitmap that tracks which records are programmed.

---
 rtl/flash_pkg.sv | 30 +++
 rtl/flash_array.sv | 69 ++++++
 rtl/flash_store.sv | 161 ++++++++++++++++
 tb/tb_flash_store.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared types and defaults for the flash record store.
// FLASH_PARITY_EN adds per-lane parity storage and checking.
package flash_pkg;

  localparam int FLASH_DEPTH  = 16;
  localparam int FLASH_ADDR_W = 4;
  localparam int FLASH_DATA_W = 256;
  localparam int PAR_LANES    = 8;

  typedef enum logic [1:0] {
    IDLE,
    PROG,
    ERASE
  } state_t;

`ifdef FLASH_PARITY_EN
  localparam int LANE_W = FLASH_DATA_W / PAR_LANES;

  // Even parity per 32-bit lane: bit l is the XOR of lane l.
  function automatic logic [PAR_LANES-1:0] lane_parity(input logic [FLASH_DATA_W-1:0] d);
    logic [PAR_LANES-1:0] p;
    p = '0;
    for (int l = 0; l < PAR_LANES; l++) begin
      p[l] = ^d[l*LANE_W +: LANE_W];
    end
    return p;
  endfunction
`endif

endpackage

// File: rtl/flash_array.sv
// Record storage with valid bitmap, one write port, one registered read port
// and a single-cycle bulk clear. FLASH_PARITY_EN adds parity bits per record.
module flash_array
  import flash_pkg::*;
#(
  parameter int DEPTH  = FLASH_DEPTH,
  parameter int ADDR_W = FLASH_ADDR_W,
  parameter int DATA_W = FLASH_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`ifdef FLASH_PARITY_EN
  input  logic [PAR_LANES-1:0] wr_par,
  output logic              rd_par_err,
`endif
  input  logic              clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  valid_reg;
`ifdef FLASH_PARITY_EN
  logic [PAR_LANES-1:0] par_reg [DEPTH];
`endif

  // Bulk clear touches every row in one cycle, so each row is its own register.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
    always_ff @(posedge clk) begin
      if (rst || clr) begin
        mem_reg[gi]   <= '0;
        valid_reg[gi] <= 1'b0;
`ifdef FLASH_PARITY_EN
        par_reg[gi]   <= '0;
`endif
      end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
        mem_reg[gi]   <= wr_data;
        valid_reg[gi] <= 1'b1;
`ifdef FLASH_PARITY_EN
        par_reg[gi]   <= wr_par;
`endif
      end
    end
  end

  // Read samples the pre-write contents, so a commit shows up one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= valid_reg[rd_addr] ? mem_reg[rd_addr] : '0;
    end
  end

`ifdef FLASH_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_par_err <= 1'b0;
    end else begin
      rd_par_err <= valid_reg[rd_addr] &&
                    (lane_parity(mem_reg[rd_addr]) != par_reg[rd_addr]);
    end
  end
`endif

endmodule

// File: rtl/flash_store.sv
// NOR-style record store: multi-cycle program/erase FSM, max/empty tracking
// and sticky drop error. FLASH_PARITY_EN adds parity_err and corrupt inputs.
module flash_store
  import flash_pkg::*;
#(
  parameter int DEPTH        = FLASH_DEPTH,
  parameter int ADDR_W       = FLASH_ADDR_W,
  parameter int DATA_W       = FLASH_DATA_W,
  parameter int PROG_CYCLES  = 8,
  parameter int ERASE_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flash_write,
  input  logic [ADDR_W-1:0] add_flash,
  input  logic [DATA_W-1:0] write_data_flash,
  input  logic              erase,
`ifdef FLASH_PARITY_EN
  input  logic              corrupt_en,
  input  logic [2:0]        corrupt_lane,
  output logic              parity_err,
`endif
  output logic [DATA_W-1:0] data_flash,
  output logic [ADDR_W-1:0] max_address,
  output logic              empty,
  output logic              busy,
  output logic              wr_err
);

  localparam int CNT_MAX = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [ADDR_W-1:0] max_reg, max_next;
  logic              empty_reg, empty_next;
  logic              wr_err_reg, wr_err_next;
  logic              commit;
  logic              clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      data_reg   <= '0;
      max_reg    <= '0;
      empty_reg  <= 1'b1;
      wr_err_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      max_reg    <= max_next;
      empty_reg  <= empty_next;
      wr_err_reg <= wr_err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    addr_next   = addr_reg;
    data_next   = data_reg;
    max_next    = max_reg;
    empty_next  = empty_reg;
    wr_err_next = wr_err_reg;
    commit      = 1'b0;
    clear       = 1'b0;
    case (state_reg)
      IDLE: begin
        // Erase has priority; a simultaneous program is dropped and flagged.
        if (erase) begin
          state_next = ERASE;
          cnt_next   = CNT_W'(ERASE_CYCLES - 1);
          if (flash_write) wr_err_next = 1'b1;
        end else if (flash_write) begin
          state_next = PROG;
          cnt_next   = CNT_W'(PROG_CYCLES - 1);
          addr_next  = add_flash;
          data_next  = write_data_flash;
        end
      end
      PROG: begin
        if (flash_write || erase) wr_err_next = 1'b1;
        if (cnt_reg == '0) begin
          commit     = 1'b1;
          state_next = IDLE;
          empty_next = 1'b0;
          if (addr_reg > max_reg) max_next = addr_reg;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ERASE: begin
        if (flash_write || erase) wr_err_next = 1'b1;
        if (cnt_reg == '0) begin
          clear      = 1'b1;
          state_next = IDLE;
          empty_next = 1'b1;
          max_next   = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef FLASH_PARITY_EN
  logic                 corrupt_pend_reg;
  logic [2:0]           corrupt_lane_reg;
  logic [PAR_LANES-1:0] wr_par;

  // A corrupt request arms a one-shot flip applied to the next committed record.
  always_ff @(posedge clk) begin
    if (rst) begin
      corrupt_pend_reg <= 1'b0;
      corrupt_lane_reg <= '0;
    end else if (corrupt_en) begin
      corrupt_pend_reg <= 1'b1;
      corrupt_lane_reg <= corrupt_lane;
    end else if (commit) begin
      corrupt_pend_reg <= 1'b0;
    end
  end

  always_comb begin
    wr_par = lane_parity(data_reg);
    if (corrupt_pend_reg) wr_par[corrupt_lane_reg] = ~wr_par[corrupt_lane_reg];
  end
`endif

  flash_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (commit),
    .wr_addr    (addr_reg),
    .wr_data    (data_reg),
`ifdef FLASH_PARITY_EN
    .wr_par     (wr_par),
    .rd_par_err (parity_err),
`endif
    .clr        (clear),
    .rd_addr    (add_flash),
    .rd_data    (data_flash)
  );

  assign max_address = max_reg;
  assign empty       = empty_reg;
  assign busy        = (state_reg != IDLE);
  assign wr_err      = wr_err_reg;

endmodule

// File: tb/tb_flash_store.sv
// Directed plus randomized bench for flash_store against an operation-level
// model (pending op with a completion edge, plain record array).
module tb_flash_store;

  localparam int DEPTH = 16;
  localparam int PROG  = 8;
  localparam int ERASE = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flash_write = 1'b0;
  logic [3:0]   add_flash = '0;
  logic [255:0] write_data_flash = '0;
  logic         erase = 1'b0;
  logic [255:0] data_flash;
  logic [3:0]   max_address;
  logic         empty;
  logic         busy;
  logic         wr_err;
`ifdef FLASH_PARITY_EN
  logic         corrupt_en = 1'b0;
  logic [2:0]   corrupt_lane = '0;
  logic         parity_err;
`endif

  always #5 clk = ~clk;

  flash_store dut (
    .clk              (clk),
    .rst              (rst),
    .flash_write      (flash_write),
    .add_flash        (add_flash),
    .write_data_flash (write_data_flash),
    .erase            (erase),
`ifdef FLASH_PARITY_EN
    .corrupt_en       (corrupt_en),
    .corrupt_lane     (corrupt_lane),
    .parity_err       (parity_err),
`endif
    .data_flash       (data_flash),
    .max_address      (max_address),
    .empty            (empty),
    .busy             (busy),
    .wr_err           (wr_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // Reference model: the record array plus at most one pending operation
  // that completes at a known edge number.
  logic [255:0] m_mem [DEPTH];
  int           m_max;
  logic         m_empty;
  logic         m_werr;
  logic [255:0] m_rd;
  bit           op_active;
  bit           op_is_erase;
  int           op_end;
  int           op_addr;
  logic [255:0] op_data;
  int           edge_no = 0;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_max = 0; m_empty = 1'b1; m_werr = 1'b0; m_rd = '0; op_active = 0;
  endtask

  task automatic model_edge(input logic w, input logic e, input int a,
                            input logic [255:0] d, input logic r);
    if (r) begin
      model_reset();
      return;
    end
    m_rd = m_mem[a];
    if (op_active) begin
      if (w || e) m_werr = 1'b1;
      if (edge_no == op_end) begin
        op_active = 0;
        if (op_is_erase) begin
          for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
          m_max = 0; m_empty = 1'b1;
        end else begin
          m_mem[op_addr] = op_data;
          if (op_addr > m_max) m_max = op_addr;
          m_empty = 1'b0;
        end
      end
    end else if (e) begin
      op_active = 1; op_is_erase = 1; op_end = edge_no + ERASE;
      if (w) m_werr = 1'b1;
    end else if (w) begin
      op_active = 1; op_is_erase = 0; op_end = edge_no + PROG;
      op_addr = a; op_data = d;
    end
  endtask

  task automatic cycle(input logic w, input logic e, input int a,
                       input logic [255:0] d, input logic r);
    flash_write = w; erase = e; add_flash = 4'(a); write_data_flash = d; rst = r;
    @(posedge clk);
    edge_no++;
    model_edge(w, e, a, d, r);
    if (w || e || r)
      $display("cyc %0d rst=%b wr=%b er=%b addr=%0d data=%h", edge_no, r, w, e, a, d[31:0]);
    @(negedge clk);
    check_eq("data_flash", data_flash, m_rd);
    check_eq("busy", 256'(busy), 256'(op_active));
    check_eq("max_address", 256'(max_address), 256'(m_max));
    check_eq("empty", 256'(empty), 256'(m_empty));
    check_eq("wr_err", 256'(wr_err), 256'(m_werr));
`ifdef FLASH_PARITY_EN
    check_eq("parity_err", 256'(parity_err), 256'(0));
`endif
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle(input int n, input int a);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, (a < 0) ? int'($urandom_range(0, DEPTH-1)) : a, rand256(), 1'b0);
  endtask

  initial begin
    logic [255:0] pat_a5;
    pat_a5 = {32{8'hA5}};
    model_reset();

    // Reset, then read address 3.
    cycle(1'b0, 1'b0, 3, '0, 1'b1);
    cycle(1'b0, 1'b0, 3, '0, 1'b1);
    idle(2, 3);

    // Program 5, watching the address across the whole busy window.
    cycle(1'b1, 1'b0, 5, pat_a5, 1'b0);
    idle(12, 5);

    // Max tracking: 2, 9, then 4 keeps 9.
    cycle(1'b1, 1'b0, 2, rand256(), 1'b0);
    idle(10, 2);
    cycle(1'b1, 1'b0, 9, rand256(), 1'b0);
    idle(10, 9);
    cycle(1'b1, 1'b0, 4, rand256(), 1'b0);
    idle(10, 4);

    // Second request on the third busy cycle is dropped.
    cycle(1'b1, 1'b0, 6, rand256(), 1'b0);
    idle(2, 6);
    cycle(1'b1, 1'b0, 6, rand256(), 1'b0);
    idle(10, 6);

    // Program 7, erase, then sweep every address.
    cycle(1'b1, 1'b0, 7, rand256(), 1'b0);
    idle(10, 7);
    cycle(1'b0, 1'b1, 7, '0, 1'b0);
    idle(34, 7);
    for (int i = 0; i < DEPTH; i++) idle(1, i);

    // Erase and program together: erase wins.
    cycle(1'b1, 1'b1, 3, rand256(), 1'b0);
    idle(34, 3);

    // Reset in the middle of a program aborts it.
    cycle(1'b1, 1'b0, 1, rand256(), 1'b0);
    idle(3, 1);
    cycle(1'b0, 1'b0, 1, '0, 1'b1);
    idle(12, 1);

    // Randomized traffic, with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      int roll;
      roll = int'($urandom_range(0, 399));
      cycle(roll < 60, (roll >= 60 && roll < 66) || roll == 0,
            int'($urandom_range(0, DEPTH-1)), rand256(), roll == 399);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
